// File: rtl/array_drain.sv
// array_drain: output drain stage for the Eyeriss array.
// Shifts HEIGHT partial-sum rows out of the array and requantizes each lane
// (round half up, arithmetic shift, saturate). Each row is written to a row
// FIFO that streams rows out on valid/ready. Before a drain starts, FIFO space
// for the whole drain is reserved, so no array data is lost.
// Optional feature: define OFM_RELU_EN to clamp negative outputs to zero.
module array_drain #(
  parameter int HEIGHT = 12,
  parameter int WIDTH  = 14,
  parameter int OWIDTH = 24,
  parameter int QWIDTH = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4:0]               shift,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         en_o,
  output logic [WIDTH-1:0]         clr_o,
  input  logic signed [OWIDTH-1:0] ofm [WIDTH],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [QWIDTH-1:0] out_data [WIDTH]
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic signed [OWIDTH:0] QMAX = (OWIDTH+1)'((2 ** (QWIDTH - 1)) - 1);
  localparam logic signed [OWIDTH:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN, FLUSH} state_t;

  state_t                    state;
  logic [RCW-1:0]            row_cnt;
  logic                      flush_cnt;
  logic [4:0]                shift_q;
  logic [CW-1:0]             count, count_next, reserved, free;
  logic [PW-1:0]             rd_ptr, wr_ptr, rd_next;
  logic                      room, enter_drain, push, pop;
  logic                      en_d1, last_d1, s1_valid;
  logic signed [OWIDTH-1:0]  s1_data [WIDTH];
  logic signed [QWIDTH-1:0]  q_row [WIDTH];
  logic signed [QWIDTH-1:0]  mem [DEPTH][WIDTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round half up at OWIDTH+1 bits, arithmetic shift, then saturate.
  function automatic logic signed [QWIDTH-1:0] requant(input logic signed [OWIDTH-1:0] x,
                                                       input logic [4:0] sh);
    logic signed [OWIDTH:0]   wide, rnd, r;
    logic signed [QWIDTH-1:0] res;
    wide = {x[OWIDTH-1], x};
    rnd  = '0;
    if (sh != '0) rnd[sh - 5'd1] = 1'b1;
    r = (wide + rnd) >>> sh;
    if (r > QMAX)      res = QMAX[QWIDTH-1:0];
    else if (r < QMIN) res = QMIN[QWIDTH-1:0];
    else               res = r[QWIDTH-1:0];
`ifdef OFM_RELU_EN
    if (res[QWIDTH-1]) res = '0;
`else
`endif
    return res;
  endfunction

  // Free space excludes rows already promised to an in-progress drain.
  always_comb begin
    free        = CW'(DEPTH) - count - reserved;
    room        = (free >= CW'(HEIGHT));
    enter_drain = ((state == IDLE) && start && room) || ((state == WAIT) && room);
    push        = s1_valid;
    pop         = out_valid && out_ready;
    rd_next     = ptr_inc(rd_ptr);
    count_next  = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // Lane-wise requantization of the stage-1 row.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) q_row[i] = requant(s1_data[i], shift_q);
  end

  // Control FSM with registered busy/en_o/clr_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      flush_cnt <= 1'b0;
      shift_q   <= '0;
      busy      <= 1'b0;
      en_o      <= '0;
      clr_o     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift_q <= shift;
          busy    <= 1'b1;
          row_cnt <= '0;
          if (room) begin
            state <= DRAIN;
            en_o  <= '1;
            clr_o <= '1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (room) begin
          state <= DRAIN;
          en_o  <= '1;
          clr_o <= '1;
        end
        DRAIN: begin
          if (row_cnt == RCW'(HEIGHT - 1)) begin
            state     <= FLUSH;
            en_o      <= '0;
            clr_o     <= '0;
            row_cnt   <= '0;
            flush_cnt <= 1'b0;
          end else begin
            row_cnt <= row_cnt + RCW'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flush_cnt <= 1'b0;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture pipeline: array output lands one cycle after each DRAIN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1    <= 1'b0;
      last_d1  <= 1'b0;
      s1_valid <= 1'b0;
      done     <= 1'b0;
      s1_data  <= '{default: '0};
    end else begin
      en_d1    <= (state == DRAIN);
      last_d1  <= (state == DRAIN) && (row_cnt == RCW'(HEIGHT - 1));
      s1_valid <= en_d1;
      done     <= last_d1;
      s1_data  <= ofm;
    end
  end

  // FIFO storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_row;
  end

  // FIFO pointers, occupancy, reservation and registered head row.
  // The head register is refilled from the next slot on a pop, or takes the
  // incoming row directly when that row becomes the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      reserved  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '{default: '0};
    end else begin
      count     <= count_next;
      out_valid <= (count_next != '0);
      reserved  <= reserved + (enter_drain ? CW'(HEIGHT) : '0) - (push ? CW'(1) : '0);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_next;
      if (pop && (count > CW'(1)))
        out_data <= mem[rd_next];
      else if (push && ((count == '0) || (pop && (count == CW'(1)))))
        out_data <= q_row;
    end
  end

endmodule

// File: tb/tb_array_drain.sv
// tb_array_drain: scoreboard bench for array_drain. An array model feeds ofm
// one cycle after each en_o cycle; expected rows are queued at each start and
// compared as rows leave the FIFO. Timing landmarks are recorded per cycle.
module tb_array_drain;
  localparam int HEIGHT = 12, WIDTH = 14, OWIDTH = 24, QWIDTH = 8, DEPTH = 16;
  localparam int RW = WIDTH * QWIDTH;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [4:0] shift = '0;
  logic busy, done, out_valid;
  logic [WIDTH-1:0] en_o, clr_o;
  logic signed [OWIDTH-1:0] ofm [WIDTH];
  logic signed [QWIDTH-1:0] out_data [WIDTH];

  array_drain #(.HEIGHT(HEIGHT), .WIDTH(WIDTH), .OWIDTH(OWIDTH), .QWIDTH(QWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift(shift), .busy(busy), .done(done),
    .en_o(en_o), .clr_o(clr_o), .ofm(ofm), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic signed [OWIDTH-1:0] vals [HEIGHT][WIDTH];
  logic [QWIDTH-1:0]        exp_tab [HEIGHT][WIDTH];
  logic [RW-1:0]            sb [$];
  int checks = 0, errors = 0, cyc = 0;
  int en_cnt = 0, clr_cnt = 0, done_cnt = 0, rx_cnt = 0;
  int first_en_cyc = 0, last_en_cyc = 0, done_cyc = 0, fall_cyc = 0, ov_rise_cyc = 0;
  int model_row = 0;
  logic prev_en = 1'b0, prev_busy = 1'b0, prev_ov = 1'b0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [RW-1:0] pack_out();
    logic [RW-1:0] r;
    for (int c = 0; c < WIDTH; c++) r[c*QWIDTH +: QWIDTH] = out_data[c];
    return r;
  endfunction

  function automatic int relu(input int v);
`ifdef OFM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [QWIDTH-1:0] q_model(input logic signed [OWIDTH-1:0] x, input int sh);
    longint v, qmax;
    qmax = (longint'(1) << (QWIDTH - 1)) - 1;
    v = longint'(x);
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > qmax) v = qmax;
    if (v < -qmax - 1) v = -qmax - 1;
    v = longint'(relu(int'(v)));
    return v[QWIDTH-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Array model, event recorder and scoreboard consumer.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_row = 0;
      for (int c = 0; c < WIDTH; c++) ofm[c] = 24'h5A5A5A;
      prev_en = 1'b0; prev_busy = 1'b0; prev_ov = 1'b0;
    end else begin
      if (prev_en && model_row < HEIGHT) begin
        for (int c = 0; c < WIDTH; c++) ofm[c] = vals[model_row][c];
        model_row++;
      end else begin
        for (int c = 0; c < WIDTH; c++) ofm[c] = 24'h5A5A5A;
        if (!(en_o == '1)) model_row = 0;
      end
      if ((en_o == '1) && !prev_en) first_en_cyc = cyc;
      if (en_o == '1) begin en_cnt++; last_en_cyc = cyc; end
      if (clr_o == '1) clr_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (prev_busy && !busy) fall_cyc = cyc;
      if (out_valid && !prev_ov) ov_rise_cyc = cyc;
      if (out_valid && out_ready) begin
        rx_cnt++;
        if (sb.size() == 0) check("unexpected_row", 1, 0);
        else check("row_data", pack_out(), sb.pop_front());
      end
      prev_en = (en_o == '1); prev_busy = busy; prev_ov = out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_table();
    logic [RW-1:0] row;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) row[c*QWIDTH +: QWIDTH] = exp_tab[r][c];
      sb.push_back(row);
    end
  endtask

  task automatic load_model(input int sh, input int kind);
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++) begin
        vals[r][c] = (kind == 0) ? OWIDTH'(10 * r + c) : OWIDTH'($urandom);
        exp_tab[r][c] = q_model(vals[r][c], sh);
      end
  endtask

  task automatic pulse_start(input logic [4:0] sh, output int t);
    start = 1'b1; shift = sh; t = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while ((busy || sb.size() != 0) && k < maxc) begin tick(1); k++; end
    if (k >= maxc) check("idle_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e0, d0, r0, c0, k;
    int rin [8], rout [8];
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en", en_o, 0);
    check("rst_clr", clr_o, 0);
    check("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    tick(2);

    // Basic drain, shift 0, array value 10*row+col.
    out_ready = 1'b1;
    load_model(0, 0); push_table();
    e0 = en_cnt; c0 = clr_cnt; d0 = done_cnt; r0 = rx_cnt;
    pulse_start(5'd0, t);
    wait_idle(200);
    check("basic_first_en", first_en_cyc, t + 1);
    check("basic_last_en", last_en_cyc, t + HEIGHT);
    check("basic_en_cycles", en_cnt - e0, HEIGHT);
    check("basic_clr_cycles", clr_cnt - c0, HEIGHT);
    check("basic_valid_rise", ov_rise_cyc, t + 4);
    check("basic_done_cyc", done_cyc, t + HEIGHT + 2);
    check("basic_done_pulses", done_cnt - d0, 1);
    check("basic_busy_fall", fall_cyc, t + HEIGHT + 3);
    check("basic_rows", rx_cnt - r0, HEIGHT);

    // Rounding at shift 4 with explicit expected lanes.
    rin  = '{23, 24, -24, -25, 7, 8, -8, -9};
    rout = '{1, 2, relu(-1), relu(-2), 0, 1, 0, relu(-1)};
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++) begin
        vals[r][c] = OWIDTH'(rin[(r + c) % 8]);
        exp_tab[r][c] = QWIDTH'(rout[(r + c) % 8]);
      end
    push_table();
    pulse_start(5'd4, t);
    wait_idle(200);

    // Saturation at shift 0.
    rin  = '{32'h7FFFFF, -32'sh800000, 127, 128, -128, -129, 0, -1};
    rout = '{127, relu(-128), 127, 127, relu(-128), relu(-128), 0, relu(-1)};
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++) begin
        vals[r][c] = OWIDTH'(rin[(r + 2 * c) % 8]);
        exp_tab[r][c] = QWIDTH'(rout[(r + 2 * c) % 8]);
      end
    push_table();
    pulse_start(5'd0, t);
    wait_idle(200);

    // Backpressure and reservation: second drain waits for space.
    out_ready = 1'b0;
    r0 = rx_cnt;
    load_model(3, 1); push_table();
    pulse_start(5'd3, t);
    k = 0;
    while (busy && k < 100) begin tick(1); k++; end
    check("bp_first_finish", busy, 0);
    check("bp_fifo_full_valid", out_valid, 1);
    e0 = en_cnt;
    load_model(3, 1); push_table();
    pulse_start(5'd3, t);
    tick(5);
    check("bp_wait_no_en", en_o, 0);
    check("bp_wait_busy", busy, 1);
    out_ready = 1'b1; tick(7); out_ready = 1'b0;
    tick(4);
    check("bp_still_waiting", en_cnt - e0, 0);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    k = 0;
    while (!(en_o == '1) && k < 6) begin tick(1); k++; end
    check("bp_drain_started", (en_o == '1), 1);
    out_ready = 1'b1;
    wait_idle(300);
    check("bp_rows", rx_cnt - r0, 2 * HEIGHT);

    // Start while busy is ignored.
    load_model(7, 1); push_table();
    e0 = en_cnt; d0 = done_cnt; r0 = rx_cnt;
    pulse_start(5'd7, t);
    tick(3);
    start = 1'b1; tick(1); start = 1'b0;
    wait_idle(200);
    tick(20);
    check("ign_en_cycles", en_cnt - e0, HEIGHT);
    check("ign_done_pulses", done_cnt - d0, 1);
    check("ign_rows", rx_cnt - r0, HEIGHT);

    // Reset mid-drain at row 5, then a normal drain.
    out_ready = 1'b0;
    load_model(0, 1);
    pulse_start(5'd0, t);
    k = 1;
    while (k < 6 && busy) begin tick(1); if (en_o == '1) k++; end
    check("mid_row5_en", (en_o == '1), 1);
    check("mid_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", en_o, 0);
    check("mid_rst_clr", clr_o, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_empty", out_valid, 0);
    out_ready = 1'b1;
    load_model(23, 1); push_table();
    e0 = en_cnt; d0 = done_cnt; r0 = rx_cnt;
    pulse_start(5'd23, t);
    wait_idle(200);
    check("post_rst_en_cycles", en_cnt - e0, HEIGHT);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_rows", rx_cnt - r0, HEIGHT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
